// File: rtl/cpu_debug_cmd_sysclk.sv
// System-clock half of the CPU JTAG debug slave: synchronises update strobes and queues commands.
// Optional macro CPU_DEBUG_CMD_TIMESTAMP_EN adds a 16-bit timestamp per queued command (cmd_ts).
module cpu_debug_cmd_sysclk #(
  parameter int unsigned SR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [SR_WIDTH-1:0]           sr,
  input  logic                          cmd_ready,
  input  logic                          clear_overflow,
  output logic                          cmd_valid,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [SR_WIDTH-1:0]           cmd_data,
  output logic [(2**IR_WIDTH)-1:0]      take_action,
  output logic                          uir_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  output logic [15:0]                   cmd_ts,
`endif
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned NA = 2 ** IR_WIDTH;
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  localparam int unsigned EW = 16 + IR_WIDTH + SR_WIDTH;
`else
  localparam int unsigned EW = IR_WIDTH + SR_WIDTH;
`endif

  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic [SYNC_STAGES:0]   live_q, live_d;
  logic                   udr_hist_q, udr_hist_d;
  logic                   uir_hist_q, uir_hist_d;
  logic                   push_q, push_d;
  logic                   uir_edge_q, uir_edge_d;
  logic [PW-1:0]          wr_q, wr_d;
  logic [PW-1:0]          rd_q, rd_d;
  logic                   overflow_q, overflow_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          entry_w;
  logic [EW-1:0]          head;
  logic                   full, pop, wr_en, drop;

`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  logic [15:0] ts_q, ts_d;
`endif

  always_comb begin
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    // live_q marks which synchroniser/history stages hold a real post-reset sample, so a level
    // already high at reset release never looks like a rising edge.
    live_d     = {live_q[SYNC_STAGES-1:0], 1'b1};
    udr_hist_d = udr_sync_q[SYNC_STAGES-1];
    uir_hist_d = uir_sync_q[SYNC_STAGES-1];
    push_d     = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q & live_q[SYNC_STAGES];
    uir_edge_d = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q & live_q[SYNC_STAGES];
  end

  always_comb begin
    cmd_valid  = (wr_q != rd_q);
    full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop        = cmd_valid & cmd_ready;
    wr_en      = push_q & (~full | pop);
    drop       = push_q & full & ~pop;
    wr_d       = wr_q + PW'(wr_en);
    rd_d       = rd_q + PW'(pop);
    overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
    fifo_level = wr_q - rd_q;
  end

`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  assign ts_d    = ts_q + 16'd1;
  assign entry_w = {ts_q, ir_in, sr};
`else
  assign entry_w = {ir_in, sr};
`endif

  assign head = mem_q[rd_q[AW-1:0]];

  always_comb begin
    cmd_ir      = cmd_valid ? head[SR_WIDTH +: IR_WIDTH] : '0;
    cmd_data    = cmd_valid ? head[SR_WIDTH-1:0] : '0;
    take_action = pop ? (NA'(1) << cmd_ir) : '0;
    uir_pulse   = uir_edge_q;
    overflow    = overflow_q;
  end

`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  assign cmd_ts = cmd_valid ? head[EW-1 -: 16] : 16'd0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      live_q     <= '0;
      udr_hist_q <= 1'b0;
      uir_hist_q <= 1'b0;
      push_q     <= 1'b0;
      uir_edge_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      udr_sync_q <= udr_sync_d;
      uir_sync_q <= uir_sync_d;
      live_q     <= live_d;
      udr_hist_q <= udr_hist_d;
      uir_hist_q <= uir_hist_d;
      push_q     <= push_d;
      uir_edge_q <= uir_edge_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= 16'd0;
    end else begin
      ts_q <= ts_d;
    end
  end
`endif

  // Storage needs no reset: outputs are masked by cmd_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= entry_w;
    end
  end

endmodule

// File: tb/tb_cpu_debug_cmd_sysclk.sv
// Directed bench for cpu_debug_cmd_sysclk: scoreboard of expected commands checked on every pop.
module tb_cpu_debug_cmd_sysclk;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_udr, vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready, clear_overflow;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [3:0]  take_action;
  logic        uir_pulse;
  logic [2:0]  fifo_level;
  logic        overflow;
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  logic [15:0] cmd_ts;
`endif

  int compared   = 0;
  int mismatched = 0;
  int max_lvl    = 0;
  logic [39:0] exp_q [$];

  cpu_debug_cmd_sysclk dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .clear_overflow (clear_overflow),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .cmd_data       (cmd_data),
    .take_action    (take_action),
    .uir_pulse      (uir_pulse),
    .fifo_level     (fifo_level),
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
    .cmd_ts         (cmd_ts),
`endif
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic udr(input logic [1:0] ir, input logic [37:0] d, input bit accept);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
    if (accept) exp_q.push_back({ir, d});
    cyc(3);
    vs_udr = 1'b0;
    cyc(5);
  endtask

  // Scoreboard: every handshake pops the oldest expected command.
  always @(negedge clk) begin
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty_on_pop", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [39:0] e;
        logic [3:0]  oh;
        e  = exp_q.pop_front();
        oh = 4'b0001 << e[39:38];
        check("pop_cmd_ir", 64'(cmd_ir), 64'(e[39:38]));
        check("pop_cmd_data", 64'(cmd_data), 64'(e[37:0]));
        check("pop_take_action", 64'(take_action), 64'(oh));
      end
    end else begin
      check("idle_take_action", 64'(take_action), 64'd0);
    end
  end

  initial begin
    int cnt;
    reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0;
    ir_in = '0; sr = '0; cmd_ready = 1'b0; clear_overflow = 1'b0;

    // Reset with vs_udr held high
    cyc(3);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_uir_pulse", 64'(uir_pulse), 64'd0);
    check("rst_take_action", 64'(take_action), 64'd0);
    check("rst_cmd_ir", 64'(cmd_ir), 64'd0);
    check("rst_cmd_data", 64'(cmd_data), 64'd0);
    reset_n = 1'b1;
    cyc(10);
    check("release_high_no_push", 64'(fifo_level), 64'd0);
    check("release_high_no_valid", 64'(cmd_valid), 64'd0);
    vs_udr = 1'b0;
    cyc(5);

    // Single capture and latency
    ir_in = 2'b01; sr = 38'h2A_DEAD_BEEF; vs_udr = 1'b1;
    exp_q.push_back({2'b01, 38'h2A_DEAD_BEEF});
    cyc(S + 1);
    check("lat_not_yet_valid", 64'(cmd_valid), 64'd0);
    cyc(1);
    check("lat_valid", 64'(cmd_valid), 64'd1);
    check("head_ir", 64'(cmd_ir), 64'h1);
    check("head_data", 64'(cmd_data), 64'h2A_DEAD_BEEF);
    vs_udr = 1'b0;
    cmd_ready = 1'b1;
    #1;
    check("single_take_action", 64'(take_action), 64'b0010);
    cyc(1);
    check("single_valid_after_pop", 64'(cmd_valid), 64'd0);
    check("single_take_action_off", 64'(take_action), 64'd0);
    cmd_ready = 1'b0;
    cyc(6);

    // Overflow: five pushes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) udr(2'(i), 38'(i), i <= 4);
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);
    cmd_ready = 1'b1;
    cyc(4);
    cmd_ready = 1'b0;
    check("ovf_drained", 64'(fifo_level), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    cyc(1);
    clear_overflow = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Full plus pop on the push cycle
    for (int i = 0; i < 4; i++) udr(2'(i), 38'(10 + i), 1'b1);
    check("full_level", 64'(fifo_level), 64'd4);
    ir_in = 2'b11; sr = 38'd14; vs_udr = 1'b1;
    exp_q.push_back({2'b11, 38'd14});
    cyc(S + 1);
    cmd_ready = 1'b1;
    vs_udr = 1'b0;
    cyc(1);
    cmd_ready = 1'b0;
    check("full_pop_level", 64'(fifo_level), 64'd4);
    check("full_pop_no_ovf", 64'(overflow), 64'd0);
    cyc(4);
    cmd_ready = 1'b1;
    cyc(4);
    check("full_pop_drained", 64'(fifo_level), 64'd0);
    check("full_pop_sb_empty", 64'(exp_q.size()), 64'd0);

    // Wrap-around with immediate pops
    max_lvl = 0;
    for (int i = 0; i < 10; i++) udr(2'(i % 4), 38'(100 + i * 3), 1'b1);
    check("wrap_max_level", 64'(max_lvl), 64'd1);
    check("wrap_sb_empty", 64'(exp_q.size()), 64'd0);
    cmd_ready = 1'b0;

    // UIR pulse
    vs_uir = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      cnt += int'(uir_pulse);
    end
    vs_uir = 1'b0;
    check("uir_one_pulse", 64'(cnt), 64'd1);
    check("uir_level", 64'(fifo_level), 64'd0);
    cyc(4);

    // Mid-operation reset
    for (int i = 0; i < 3; i++) udr(2'(i), 38'(200 + i), 1'b1);
    check("mid_level", 64'(fifo_level), 64'd3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(cmd_valid), 64'd0);
    exp_q.delete();
    cyc(2);
    reset_n = 1'b1;
    cyc(5);
    check("mid_rst_level", 64'(fifo_level), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
